bu_pipe: RTL and testbench
==========================

Name: bu_pipe

Overview:
Pipelined, parametrised modular butterfly unit for the NTT/INTT datapath (default Dilithium modulus Q=8380417, 23-bit coefficients).
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) butterflies, selected per transaction.
- Accepts one butterfly per cycle through a valid/ready handshake; results are fully reduced into [0,Q).
- Carries a user tag alongside the data so the NTT controller can track coefficient indices.

Parameters:
W, 23, coefficient width in bits; Q < 2^W
Q, 8380417, modulus
MU, 8396807, Barrett constant, floor(2^(2W)/Q); must match Q and W
TAG_W, 8, width of the pass-through tag

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
mode  in  1  0 = CT butterfly, 1 = GS butterfly; sampled with in_valid
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept an input this cycle
x  in  W  first operand, in [0,Q)
y  in  W  second operand, in [0,Q)
tf  in  W  twiddle factor, in [0,Q)
tag_in  in  TAG_W  opaque tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
a  out  W  first result
b  out  W  second result
tag_out  out  TAG_W  tag of the current result
busy  out  1  one or more pipeline stages hold valid data

Behaviour:
- Reset (rst_n low at a clock edge):
  - All stage valid bits clear; out_valid=0, busy=0.
  - a, b and tag_out reset to 0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-stream discards all in-flight transactions; none are emitted afterwards.
- Arithmetic, all results mod Q in [0,Q):
  - CT: P = y*tf mod Q; a = (x+P) mod Q; b = (x−P) mod Q.
  - GS: a = (x+y) mod Q; b = ((x−y)*tf) mod Q.
- Pipeline stages, each with a valid bit:
  - S1 operand prep: GS computes the sum and difference here; CT passes x and y through.
  - S2 multiply: 2W-bit product of the multiplicand and tf.
  - S3 Barrett reduce:
    - qe = ((p >> (W−1)) * MU) >> (W+1)
    - r = p − qe*Q
    - Conditional subtraction of Q at most twice, giving r in [0,Q).
  - S4 post add/sub: CT only. GS forwards S1's sum and the reduced product.
- Mode and tag travel with each transaction; the pipeline never mixes a transaction's fields.
- Add/sub reduction:
  - Sum: compute x+P in W+1 bits; subtract Q if the result ≥ Q.
  - Difference: add Q if x−P is negative.
- Handshake:
  - advance = !out_valid | out_ready
  - in_ready = advance
  - A transfer occurs when in_valid && in_ready, and likewise when out_valid && out_ready.
- Stall: when advance=0 every stage holds, and a, b, tag_out stay stable while out_valid=1.
- Latency and throughput:
  - Input accepted at edge t with no stall gives out_valid=1 after edge t+4.
  - Throughput is 1 per cycle. Order is preserved, with no loss and no duplication.
- Bubbles: a stage with valid=0 advances as a bubble. Bubbles are not collapsed during a stall; a global stall is required.
- Simultaneous accept and emit in one cycle is legal and sustains full throughput.
- busy = OR of the four stage valid bits.
- Out-of-range operands (≥ Q) are a caller error. Outputs are unspecified, but handshake and tag behaviour remain correct.

Decomposition:
- Package bu_pkg holds:
  - default W, Q, MU
  - mode enum BU_CT=0, BU_GS=1
  - helper function mod_add
  - helper function mod_sub
- One sub-module, barrett_reduce, is natural:
  - parametrised W, Q, MU
  - input 2W-bit product, output W-bit result
  - combinational
  - instantiated in S3

Test Plan:
- CT, x=5, y=3, tf=2 -> a=11, b=8380416, out_valid exactly 4 cycles after accept.
- GS, x=5, y=3, tf=2 -> a=8, b=4. Then CT with x=8380416, y=1, tf=1 -> a=0, b=8380415 (wrap in both directions).
- CT, x=0, y=8380416, tf=8380416 -> a=1, b=8380416 (maximum product, exercises the Barrett correction path).
- Stream of 8 transactions with tags 0..7 and alternating mode, out_ready low for 3 cycles mid-stream:
  - in_ready drops for those cycles.
  - Outputs hold stable.
  - All 8 results emerge in tag order with the correct values.
- rst_n low for one cycle while 3 transactions are in flight -> next cycle out_valid=0, busy=0, in_ready=1; the dropped tags never appear.
- 10,000 random in-range operands and modes with random out_ready, compared against a reference model -> zero mismatches, one-per-cycle throughput while out_ready=1.

Source files
------------

// File: rtl/bu_pkg.sv
// Shared types, default parameters and modular add/sub helpers for the
// NTT/INTT butterfly pipeline.
package bu_pkg;

  localparam int          BU_W  = 23;
  localparam int unsigned BU_Q  = 8380417;
  localparam int unsigned BU_MU = 8396807;

  typedef enum logic {
    BU_CT = 1'b0,
    BU_GS = 1'b1
  } bu_mode_e;

  // Operands are zero-extended to 32 bits so one helper serves any W up to 31.
  function automatic logic [31:0] mod_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] q);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[31:0];
  endfunction

  function automatic logic [31:0] mod_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] q);
    logic [31:0] d;
    d = a - b;
    if (a < b) d = d + q;
    return d;
  endfunction

endpackage

// File: rtl/bu_pipe_if.sv
// Valid/ready handshake bundle between the NTT controller and the butterfly.
interface bu_pipe_if
  import bu_pkg::*;
#(
  parameter int W     = BU_W,
  parameter int TAG_W = 8
);

  bu_mode_e           mode;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       x;
  logic [W-1:0]       y;
  logic [W-1:0]       tf;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic [TAG_W-1:0]   tag_out;

  modport slave (
    input  mode, in_valid, x, y, tf, tag_in, out_ready,
    output in_ready, out_valid, a, b, tag_out
  );

  modport master (
    output mode, in_valid, x, y, tf, tag_in, out_ready,
    input  in_ready, out_valid, a, b, tag_out
  );

endinterface

// File: rtl/bu_pipe_barrett_reduce.sv
// Combinational Barrett reduction of a 2W-bit product into [0,Q).
module barrett_reduce #(
  parameter int          W  = 23,
  parameter int unsigned Q  = 8380417,
  parameter int unsigned MU = 8396807
) (
  input  logic [2*W-1:0] p_i,
  output logic [W-1:0]   r_o
);

  localparam logic [2*W+1:0] MU_X = (2*W+2)'(MU);
  localparam logic [2*W+1:0] Q_X  = (2*W+2)'(Q);
  localparam logic [W+1:0]   Q_R  = (W+2)'(Q);

  logic [2*W+1:0] prod;
  logic [2*W+1:0] qeq;
  logic [2*W+1:0] diff;
  logic [W:0]     qe;
  logic [W+1:0]   r0;
  logic [W+1:0]   r1;
  logic [W+1:0]   r2;

  // The quotient estimate undershoots by at most 2, so r0 < 3Q fits in W+2 bits.
  always_comb begin
    prod = (2*W+2)'(p_i >> (W-1)) * MU_X;
    qe   = (W+1)'(prod >> (W+1));
    qeq  = (2*W+2)'(qe) * Q_X;
    diff = (2*W+2)'(p_i) - qeq;
    r0   = (W+2)'(diff);
    r1   = (r0 >= Q_R) ? r0 - Q_R : r0;
    r2   = (r1 >= Q_R) ? r1 - Q_R : r1;
    r_o  = W'(r2);
  end

endmodule

// File: rtl/bu_pipe.sv
// Pipelined CT/GS modular butterfly: input register, operand prep, multiply,
// Barrett reduce, post add/sub into the output register, under one global stall.
module bu_pipe
  import bu_pkg::*;
#(
  parameter int          W     = BU_W,
  parameter int unsigned Q     = BU_Q,
  parameter int unsigned MU    = BU_MU,
  parameter int          TAG_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  bu_pipe_if.slave   bus,
  output logic       busy
);

  logic adv;

  logic               v0_q, v1_q, v2_q, v3_q, out_valid_q;
  bu_mode_e           mode0_q, mode1_q, mode2_q, mode3_q;
  logic [TAG_W-1:0]   tag0_q, tag1_q, tag2_q, tag3_q, tag_out_q;
  logic [W-1:0]       x0_q, y0_q, tf0_q;
  logic [W-1:0]       u1_q, m1_q, tf1_q;
  logic [W-1:0]       u2_q;
  logic [2*W-1:0]     p2_q;
  logic [W-1:0]       u3_q, r3_q;
  logic [W-1:0]       a_q, b_q;

  logic [W-1:0]       u1_d, m1_d, r3_d, a_d, b_d;
  logic [2*W-1:0]     p2_d;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.tag_out  = tag_out_q;
  assign busy         = v0_q || v1_q || v2_q || v3_q || out_valid_q;

  // GS folds x+y / x-y before the multiply; CT multiplies y directly.
  always_comb begin
    u1_d = x0_q;
    m1_d = y0_q;
    if (mode0_q == BU_GS) begin
      u1_d = W'(mod_add(32'(x0_q), 32'(y0_q), Q));
      m1_d = W'(mod_sub(32'(x0_q), 32'(y0_q), Q));
    end
  end

  assign p2_d = (2*W)'(m1_q) * (2*W)'(tf1_q);

  barrett_reduce #(.W(W), .Q(Q), .MU(MU)) u_barrett (
    .p_i (p2_q),
    .r_o (r3_d)
  );

  always_comb begin
    a_d = u3_q;
    b_d = r3_q;
    if (mode3_q == BU_CT) begin
      a_d = W'(mod_add(32'(u3_q), 32'(r3_q), Q));
      b_d = W'(mod_sub(32'(u3_q), 32'(r3_q), Q));
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mode0_q <= bus.mode;
      tag0_q  <= bus.tag_in;
      x0_q    <= bus.x;
      y0_q    <= bus.y;
      tf0_q   <= bus.tf;
      mode1_q <= mode0_q;
      tag1_q  <= tag0_q;
      u1_q    <= u1_d;
      m1_q    <= m1_d;
      tf1_q   <= tf0_q;
      mode2_q <= mode1_q;
      tag2_q  <= tag1_q;
      u2_q    <= u1_q;
      p2_q    <= p2_d;
      mode3_q <= mode2_q;
      tag3_q  <= tag2_q;
      u3_q    <= u2_q;
      r3_q    <= r3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag_out_q   <= '0;
    end else if (adv) begin
      v0_q        <= bus.in_valid;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      if (v3_q) begin
        a_q       <= a_d;
        b_q       <= b_d;
        tag_out_q <= tag3_q;
      end
    end
  end

endmodule

// File: tb/tb_bu_pipe.sv
// Self-checking bench for bu_pipe: directed corner cases, stall, reset flush
// and a long random run against an arithmetic reference model.
module tb_bu_pipe;
  import bu_pkg::*;

  localparam int     W     = 23;
  localparam int     TAG_W = 8;
  localparam longint QL    = 64'd8380417;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  bu_pipe_if #(.W(W), .TAG_W(TAG_W)) bif ();

  bu_pipe #(.W(W), .Q(8380417), .MU(8396807), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_emit  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic exp_t ref_bf(input bu_mode_e m, input longint x, input longint y,
                                  input longint tf, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint p, ra, rb;
    if (m == BU_CT) begin
      p  = (y * tf) % QL;
      ra = (x + p) % QL;
      rb = (x - p + QL) % QL;
    end else begin
      ra = (x + y) % QL;
      rb = (((x - y + QL) % QL) * tf) % QL;
    end
    e.tag = tag;
    e.a   = W'(ra);
    e.b   = W'(rb);
    return e;
  endfunction

  task automatic drive(input bit v, input bu_mode_e m, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] tf,
                       input logic [TAG_W-1:0] tag);
    bif.in_valid = v;
    bif.mode     = m;
    bif.x        = x;
    bif.y        = y;
    bif.tf       = tf;
    bif.tag_in   = tag;
  endtask

  // One clock: records accept/emit from pre-edge values, scores any emitted result.
  task automatic cycle(output bit acc);
    bit               emit;
    exp_t             e;
    logic [W-1:0]     oa, ob;
    logic [TAG_W-1:0] ot;
    #1;
    acc  = rst_n && bif.in_valid && bif.in_ready;
    emit = rst_n && bif.out_valid && bif.out_ready;
    oa = bif.a;
    ob = bif.b;
    ot = bif.tag_out;
    if (acc)
      sb.push_back(ref_bf(bif.mode, longint'(bif.x), longint'(bif.y), longint'(bif.tf), bif.tag_in));
    @(posedge clk);
    #1;
    if (emit) begin
      n_emit++;
      if (sb.size() == 0) begin
        chk("spurious_out_pending", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_tag", 64'(ot), 64'(e.tag));
        chk("sb_a", 64'(oa), 64'(e.a));
        chk("sb_b", 64'(ob), 64'(e.b));
      end
    end
  endtask

  task automatic single(input string nm, input bu_mode_e m, input int x, input int y,
                        input int tf, input int ea, input int eb, input logic [TAG_W-1:0] tag);
    bit acc;
    int lat;
    drive(1'b1, m, W'(x), W'(y), W'(tf), tag);
    bif.out_ready = 1'b1;
    cycle(acc);
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    bif.in_valid = 1'b0;
    lat = 0;
    while (!bif.out_valid && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_a"}, 64'(bif.a), 64'(ea));
    chk({nm, "_b"}, 64'(bif.b), 64'(eb));
    chk({nm, "_tag"}, 64'(bif.tag_out), 64'(tag));
    cycle(acc);
  endtask

  initial begin
    bit               acc;
    int               idx, stall_left, emit0, sent, thr_miss, seen;
    bit               stalled, ordy, vld;
    logic [W-1:0]     ha, hb;
    logic [TAG_W-1:0] ht;
    logic [W-1:0]     sx[8], sy[8], stf[8];

    drive(1'b0, BU_CT, '0, '0, '0, '0);
    bif.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("rst_a", 64'(bif.a), 64'd0);
    chk("rst_b", 64'(bif.b), 64'd0);
    chk("rst_tag", 64'(bif.tag_out), 64'd0);

    single("ct_small", BU_CT, 5, 3, 2, 11, 8380416, 8'h11);
    single("gs_small", BU_GS, 5, 3, 2, 8, 4, 8'h22);
    single("ct_wrap", BU_CT, 8380416, 1, 1, 0, 8380415, 8'h33);
    single("ct_maxprod", BU_CT, 0, 8380416, 8380416, 1, 8380416, 8'h44);

    // 8-deep stream with a 3-cycle downstream stall once outputs start.
    for (int i = 0; i < 8; i++) begin
      sx[i]  = W'($urandom_range(0, 8380416));
      sy[i]  = W'($urandom_range(0, 8380416));
      stf[i] = W'($urandom_range(0, 8380416));
    end
    idx = 0;
    stalled = 1'b0;
    stall_left = 0;
    emit0 = n_emit;
    for (int c = 0; c < 100; c++) begin
      if (idx == 8 && sb.size() == 0) break;
      if (idx < 8) drive(1'b1, (idx % 2 == 1) ? BU_GS : BU_CT, sx[idx], sy[idx], stf[idx], TAG_W'(idx));
      else bif.in_valid = 1'b0;
      if (!stalled && bif.out_valid) begin
        stalled = 1'b1;
        stall_left = 3;
        ha = bif.a;
        hb = bif.b;
        ht = bif.tag_out;
      end
      bif.out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        #1;
        chk("stall_in_ready", 64'(bif.in_ready), 64'd0);
      end
      cycle(acc);
      if (stall_left > 0) begin
        chk("stall_hold_valid", 64'(bif.out_valid), 64'd1);
        chk("stall_hold_a", 64'(bif.a), 64'(ha));
        chk("stall_hold_b", 64'(bif.b), 64'(hb));
        chk("stall_hold_tag", 64'(bif.tag_out), 64'(ht));
        stall_left--;
      end
      if (acc) idx++;
    end
    chk("stream_sent", 64'(idx), 64'd8);
    chk("stream_emitted", 64'(n_emit - emit0), 64'd8);

    // Reset with three transactions in flight: they must vanish.
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BU_CT, W'(i + 1), W'(i + 2), W'(3), TAG_W'(8'hA0 + i));
      cycle(acc);
      chk("rst_fill_accept", 64'(acc), 64'd1);
    end
    bif.in_valid = 1'b0;
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b1;
    sb.delete();
    bif.out_ready = 1'b0;
    #1;
    chk("flush_out_valid", 64'(bif.out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(bif.in_ready), 64'd1);
    bif.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(acc);
      if (bif.out_valid) seen++;
    end
    chk("flush_no_output", 64'(seen), 64'd0);

    // Random run with random backpressure.
    sent = 0;
    thr_miss = 0;
    for (int c = 0; c < 40000; c++) begin
      if (sent >= 10000 && sb.size() == 0) break;
      if (sent < 10000)
        drive(1'b1, bu_mode_e'($urandom_range(0, 1)), W'($urandom_range(0, 8380416)),
              W'($urandom_range(0, 8380416)), W'($urandom_range(0, 8380416)), TAG_W'(sent));
      else
        bif.in_valid = 1'b0;
      bif.out_ready = ($urandom_range(0, 3) != 0);
      ordy = bif.out_ready;
      vld  = bif.in_valid;
      cycle(acc);
      if (vld && ordy && !acc) thr_miss++;
      if (acc) sent++;
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_throughput", 64'(thr_miss), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
